// File: rtl/ccip_mmio_responder.sv
// CCI-P MMIO responder: serves the AFU DFH/ID/CSR space locally, forwards
// accesses at byte offset 0x100 and above to user logic, and returns every
// read as one c2 response carrying the original tid, in request order.
module ccip_mmio_responder #(
  parameter logic [63:0] DFH_VAL     = 64'h1000_0100_0000_0000,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter int unsigned USR_TIMEOUT = 256,
  parameter int unsigned RDQ_DEPTH   = 4     // power of 2, at least 2
) (
  input  logic        Clk_400,
  input  logic        SoftReset_n,
  input  logic        c0_mmio_rd_valid,
  input  logic        c0_mmio_wr_valid,
  input  logic [15:0] c0_mmio_addr,
  input  logic [1:0]  c0_mmio_len,
  input  logic [8:0]  c0_mmio_tid,
  input  logic [63:0] c0_mmio_data,
  output logic        c2_rsp_valid,
  output logic [8:0]  c2_rsp_tid,
  output logic [63:0] c2_rsp_data,
  output logic        usr_rd_req,
  output logic [15:0] usr_rd_addr,
  input  logic        usr_rd_ack,
  input  logic [63:0] usr_rd_data,
  output logic        usr_wr_valid,
  output logic [15:0] usr_wr_addr,
  output logic [63:0] usr_wr_data
);

  localparam int unsigned AW = $clog2(RDQ_DEPTH);
  localparam int unsigned CW = $clog2(USR_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(USR_TIMEOUT - 1);

  // Qword index (addr[5:1]) of the only writable local register.
  localparam logic [4:0] QW_SCRATCH = 5'd5;

  typedef enum logic [1:0] {S_IDLE, S_USR_WAIT, S_RESP} state_t;

  // 4B reads return the addressed DWORD on both halves; 8B (and any other
  // length code) return the full qword.
  function automatic logic [63:0] f_fmt(input logic [63:0] d, input logic [1:0] len,
                                        input logic a0);
    logic [31:0] dw;
    dw = a0 ? d[63:32] : d[31:0];
    return (len == 2'd0) ? {dw, dw} : d;
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [8:0]    r_cur_tid;
  logic [1:0]    r_cur_len;
  logic          r_cur_a0;
  logic [63:0]   r_scratch;
  logic [31:0]   r_rd_count;
  logic [15:0]   r_to_count;
  logic          r_err;

  logic [8:0]    r_q_tid  [RDQ_DEPTH];
  logic [15:0]   r_q_addr [RDQ_DEPTH];
  logic [1:0]    r_q_len  [RDQ_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic          w_q_empty, w_q_full, w_push, w_pop, w_rd_drop;
  logic          w_wr_scratch, w_wr_usr, w_h_local;
  logic [8:0]    w_h_tid;
  logic [15:0]   w_h_addr;
  logic [1:0]    w_h_len;
  logic [63:0]   w_loc_data;

  // Queue status, request acceptance and write decode.
  always_comb begin
    w_q_empty    = (r_wr_ptr == r_rd_ptr);
    w_q_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A read that collides with a write, or finds the queue full, is dropped.
    w_rd_drop    = c0_mmio_rd_valid && (c0_mmio_wr_valid || w_q_full);
    w_push       = c0_mmio_rd_valid && !w_rd_drop;
    w_pop        = (r_state == S_IDLE) && !w_q_empty;
    w_wr_scratch = c0_mmio_wr_valid && (c0_mmio_addr[15:6] == '0) &&
                   (c0_mmio_addr[5:1] == QW_SCRATCH);
    w_wr_usr     = c0_mmio_wr_valid && (c0_mmio_addr[15:6] != '0);
    w_h_tid      = r_q_tid[r_rd_ptr[AW-1:0]];
    w_h_addr     = r_q_addr[r_rd_ptr[AW-1:0]];
    w_h_len      = r_q_len[r_rd_ptr[AW-1:0]];
    w_h_local    = (w_h_addr[15:6] == '0);
  end

  // Local register map as seen by the request at the head of the queue.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_loc_data = '0;
    case (w_h_addr[5:1])
      5'd0:       w_loc_data = DFH_VAL;
      5'd1:       w_loc_data = AFU_ID_L;
      5'd2:       w_loc_data = AFU_ID_H;
      QW_SCRATCH: w_loc_data = r_scratch;
      5'd6:       w_loc_data = {32'h0, r_rd_count};
      5'd7:       w_loc_data = {r_err, 47'h0, r_to_count};
      default:    w_loc_data = '0;
    endcase
  end

  // SCRATCH write and sticky ERR.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      r_scratch <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_scratch) begin
        if (c0_mmio_len != 2'd0)   r_scratch        <= c0_mmio_data;
        else if (c0_mmio_addr[0])  r_scratch[63:32] <= c0_mmio_data[31:0];
        else                       r_scratch[31:0]  <= c0_mmio_data[31:0];
      end
      if (w_rd_drop) r_err <= 1'b1;
    end
  end

  // Registered user write port: one-cycle strobe after the sampling edge.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      usr_wr_valid <= 1'b0;
      usr_wr_addr  <= '0;
      usr_wr_data  <= '0;
    end else begin
      usr_wr_valid <= w_wr_usr;
      if (w_wr_usr) begin
        usr_wr_addr <= c0_mmio_addr;
        usr_wr_data <= c0_mmio_data;
      end
    end
  end

  // Read-queue storage.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge Clk_400) begin
    if (w_push) begin
      r_q_tid[r_wr_ptr[AW-1:0]]  <= c0_mmio_tid;
      r_q_addr[r_wr_ptr[AW-1:0]] <= c0_mmio_addr;
      r_q_len[r_wr_ptr[AW-1:0]]  <= c0_mmio_len;
    end
  end

  // Read-queue pointers; the extra MSB tells full from empty.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Response FSM: pop, optionally wait on user logic, then one response pulse.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cur_tid    <= '0;
      r_cur_len    <= '0;
      r_cur_a0     <= 1'b0;
      r_rd_count   <= '0;
      r_to_count   <= '0;
      c2_rsp_valid <= 1'b0;
      c2_rsp_tid   <= '0;
      c2_rsp_data  <= '0;
      usr_rd_req   <= 1'b0;
      usr_rd_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_tid <= w_h_tid;
            r_cur_len <= w_h_len;
            r_cur_a0  <= w_h_addr[0];
            if (w_h_local) begin
              c2_rsp_valid <= 1'b1;
              c2_rsp_tid   <= w_h_tid;
              c2_rsp_data  <= f_fmt(w_loc_data, w_h_len, w_h_addr[0]);
              r_state      <= S_RESP;
            end else begin
              usr_rd_req  <= 1'b1;
              usr_rd_addr <= w_h_addr;
              r_cnt       <= '0;
              r_state     <= S_USR_WAIT;
            end
          end
        end
        S_USR_WAIT: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (usr_rd_ack) begin
            usr_rd_req   <= 1'b0;
            c2_rsp_valid <= 1'b1;
            c2_rsp_tid   <= r_cur_tid;
            c2_rsp_data  <= f_fmt(usr_rd_data, r_cur_len, r_cur_a0);
            r_state      <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            usr_rd_req   <= 1'b0;
            c2_rsp_valid <= 1'b1;
            c2_rsp_tid   <= r_cur_tid;
            c2_rsp_data  <= '1;
            if (r_to_count != 16'hFFFF) r_to_count <= r_to_count + 16'd1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          c2_rsp_valid <= 1'b0;
          c2_rsp_tid   <= '0;
          c2_rsp_data  <= '0;
          r_rd_count   <= r_rd_count + 32'd1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Directed bench for ccip_mmio_responder: a transaction-level model predicts
// every response and user write; a compare process checks them as they
// appear, and hand-computed literals pin the key scenarios.
module tb_ccip_mmio_responder;

  localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;
  localparam int          TO   = 256;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        Clk_400 = 1'b0;
  logic        SoftReset_n = 1'b0;
  logic        c0_mmio_rd_valid = 1'b0;
  logic        c0_mmio_wr_valid = 1'b0;
  logic [15:0] c0_mmio_addr = '0;
  logic [1:0]  c0_mmio_len = '0;
  logic [8:0]  c0_mmio_tid = '0;
  logic [63:0] c0_mmio_data = '0;
  logic        c2_rsp_valid;
  logic [8:0]  c2_rsp_tid;
  logic [63:0] c2_rsp_data;
  logic        usr_rd_req;
  logic [15:0] usr_rd_addr;
  logic        usr_rd_ack = 1'b0;
  logic [63:0] usr_rd_data = '0;
  logic        usr_wr_valid;
  logic [15:0] usr_wr_addr;
  logic [63:0] usr_wr_data;

  always #5 Clk_400 = ~Clk_400;

  ccip_mmio_responder #(.USR_TIMEOUT(TO), .RDQ_DEPTH(4)) dut (
    .Clk_400(Clk_400), .SoftReset_n(SoftReset_n),
    .c0_mmio_rd_valid(c0_mmio_rd_valid), .c0_mmio_wr_valid(c0_mmio_wr_valid),
    .c0_mmio_addr(c0_mmio_addr), .c0_mmio_len(c0_mmio_len),
    .c0_mmio_tid(c0_mmio_tid), .c0_mmio_data(c0_mmio_data),
    .c2_rsp_valid(c2_rsp_valid), .c2_rsp_tid(c2_rsp_tid), .c2_rsp_data(c2_rsp_data),
    .usr_rd_req(usr_rd_req), .usr_rd_addr(usr_rd_addr),
    .usr_rd_ack(usr_rd_ack), .usr_rd_data(usr_rd_data),
    .usr_wr_valid(usr_wr_valid), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
  endtask

  // ---------------- model ----------------
  typedef struct { logic [8:0] tid; logic [63:0] data; } rsp_t;
  typedef struct { logic [15:0] addr; logic [63:0] data; } uwr_t;
  rsp_t exp_rsp[$];
  uwr_t exp_uwr[$];

  logic [63:0] m_scratch  = '0;
  logic [31:0] m_rd_count = '0;
  logic [15:0] m_to_count = '0;
  logic        m_err      = 1'b0;

  function automatic logic [63:0] m_fmt(input logic [63:0] d, input logic [1:0] len,
                                        input logic a0);
    logic [31:0] dw;
    dw = a0 ? d[63:32] : d[31:0];
    return (len == 2'd0) ? {dw, dw} : d;
  endfunction

  // Local map by byte offset (DWORD address times four, qword aligned).
  function automatic logic [63:0] m_read(input logic [15:0] a, input logic [1:0] len);
    int unsigned off;
    logic [63:0] q;
    off = 32'(a) * 4;
    q = '0;
    case (off & ~32'h7)
      32'h28: q = m_scratch;
      32'h30: q = {32'h0, m_rd_count};
      32'h38: q = {m_err, 47'h0, m_to_count};
      32'h00: q = DFH;
      default: q = '0;
    endcase
    return m_fmt(q, len, a[0]);
  endfunction

  task automatic m_write(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d);
    int unsigned off;
    off = 32'(a) * 4;
    if (off >= 32'h100) exp_uwr.push_back('{a, d});
    else if ((off & ~32'h7) == 32'h28) begin
      if (len != 2'd0)  m_scratch = d;
      else if (a[0])    m_scratch[63:32] = d[31:0];
      else              m_scratch[31:0]  = d[31:0];
    end
  endtask

  // ---------------- compare process ----------------
  logic prev_valid = 1'b0;
  always @(negedge Clk_400) begin
    if (c2_rsp_valid) begin
      check("rsp_single_cycle", 64'(prev_valid), 64'd0);
      if (exp_rsp.size() == 0) check("rsp_unexpected_tid", 64'(c2_rsp_tid), 64'h3FF);
      else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        check("rsp_tid", 64'(c2_rsp_tid), 64'(e.tid));
        check("rsp_data", c2_rsp_data, e.data);
      end
    end
    if (usr_wr_valid) begin
      if (exp_uwr.size() == 0) check("uwr_unexpected_addr", 64'(usr_wr_addr), 64'h1_0000);
      else begin
        uwr_t w;
        w = exp_uwr.pop_front();
        check("uwr_addr", 64'(usr_wr_addr), 64'(w.addr));
        check("uwr_data", usr_wr_data, w.data);
      end
    end
    prev_valid = c2_rsp_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic rv, input logic wv, input logic [15:0] a,
                       input logic [1:0] len, input logic [8:0] tid, input logic [63:0] d);
    @(negedge Clk_400);
    c0_mmio_rd_valid = rv; c0_mmio_wr_valid = wv;
    c0_mmio_addr = a; c0_mmio_len = len; c0_mmio_tid = tid; c0_mmio_data = d;
    @(posedge Clk_400);
    #1;
    c0_mmio_rd_valid = 1'b0; c0_mmio_wr_valid = 1'b0;
    c0_mmio_addr = '0; c0_mmio_len = '0; c0_mmio_tid = '0; c0_mmio_data = '0;
  endtask

  task automatic rd_local(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid,
                          input bit drop);
    if (drop) m_err = 1'b1;
    else begin
      exp_rsp.push_back('{tid, m_read(a, len)});
      m_rd_count++;
    end
    drive(1'b1, 1'b0, a, len, tid, '0);
  endtask

  task automatic rd_user(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid,
                         input logic [63:0] exp_data, input bit respond);
    if (respond) begin
      exp_rsp.push_back('{tid, exp_data});
      m_rd_count++;
    end
    drive(1'b1, 1'b0, a, len, tid, '0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d);
    m_write(a, len, d);
    drive(1'b0, 1'b1, a, len, '0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk_400);
  endtask

  task automatic ack(input logic [63:0] d);
    @(negedge Clk_400);
    usr_rd_ack = 1'b1; usr_rd_data = d;
    @(posedge Clk_400);
    #1;
    usr_rd_ack = 1'b0; usr_rd_data = '0;
  endtask

  task automatic wait_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk_400);
      if (usr_rd_req) begin seen = 1'b1; break; end
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_rsp(input string name, input logic [8:0] tid, input logic [63:0] d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk_400);
      if (c2_rsp_valid) begin seen = 1'b1; break; end
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({name, "_tid"}, 64'(c2_rsp_tid), 64'(tid));
      check({name, "_data"}, c2_rsp_data, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;

    // Reset state
    idle(3);
    check("rst_rsp_valid", 64'(c2_rsp_valid), 64'd0);
    check("rst_rsp_tid",   64'(c2_rsp_tid),   64'd0);
    check("rst_rsp_data",  c2_rsp_data,       64'd0);
    check("rst_usr_req",   64'(usr_rd_req),   64'd0);
    check("rst_usr_raddr", 64'(usr_rd_addr),  64'd0);
    check("rst_uwr_valid", 64'(usr_wr_valid), 64'd0);
    check("rst_uwr_addr",  64'(usr_wr_addr),  64'd0);
    check("rst_uwr_data",  usr_wr_data,       64'd0);
    SoftReset_n = 1'b1;
    idle(2);

    // DFH read and its latency: sampled at edge N, valid during cycle N+2
    rd_local(16'h0000, 2'd1, 9'h005, 1'b0);
    @(negedge Clk_400);
    check("lat_n1_valid", 64'(c2_rsp_valid), 64'd0);
    @(negedge Clk_400);
    check("lat_n2_valid", 64'(c2_rsp_valid), 64'd1);
    check("lat_n2_tid",   64'(c2_rsp_tid),   64'h005);
    check("lat_n2_data",  c2_rsp_data,       DFH);
    idle(3);
    rd_local(16'h000C, 2'd1, 9'h006, 1'b0);
    wait_rsp("rd_count_1", 9'h006, 64'd1);
    idle(2);

    // SCRATCH 8B write, immediate 4B read of upper DWORD, then 4B write
    wr(16'h000A, 2'd1, 64'hDEAD_BEEF_0123_4567);
    rd_local(16'h000B, 2'd0, 9'h007, 1'b0);
    wait_rsp("scratch_4b_hi", 9'h007, 64'hDEADBEEF_DEADBEEF);
    idle(2);
    wr(16'h000A, 2'd0, 64'h0000_0000_1111_1111);
    rd_local(16'h000A, 2'd1, 9'h008, 1'b0);
    wait_rsp("scratch_4b_wr", 9'h008, 64'hDEADBEEF_11111111);
    idle(2);
    rd_local(16'h0001, 2'd0, 9'h009, 1'b0);
    wait_rsp("dfh_4b_hi", 9'h009, 64'h10000100_10000100);
    idle(2);

    // User write: one-cycle pulse after the sampling edge
    wr(16'h0050, 2'd1, 64'hA5A5_0000_1234_5678);
    check("uwr_pulse", 64'(usr_wr_valid), 64'd1);
    @(negedge Clk_400);
    check("uwr_addr_lit", 64'(usr_wr_addr), 64'h0050);
    @(negedge Clk_400);
    check("uwr_pulse_end", 64'(usr_wr_valid), 64'd0);

    // Stray ack while idle must not create a response
    ack(64'h0BAD);
    idle(4);
    check("stray_ack_no_rsp", 64'(c2_rsp_valid), 64'd0);

    // User read acked 3 cycles after the request rises
    rd_user(16'h0040, 2'd1, 9'h1AB, 64'h42, 1'b1);
    wait_req("usr_req_seen");
    check("usr_rd_addr", 64'(usr_rd_addr), 64'h0040);
    idle(1);
    ack(64'h42);
    check("usr_req_dropped", 64'(usr_rd_req), 64'd0);
    wait_rsp("usr_ack", 9'h1AB, 64'h42);
    @(negedge Clk_400);
    check("usr_ack_one_pulse", 64'(c2_rsp_valid), 64'd0);
    idle(2);

    // User read with no ack: request held USR_TIMEOUT cycles, then all ones
    rd_user(16'h0041, 2'd1, 9'h020, ONES, 1'b1);
    m_to_count++;
    wait_req("to_req_seen");
    cnt = 1;
    while (usr_rd_req && cnt < 1000) begin
      @(negedge Clk_400);
      if (usr_rd_req) cnt++;
    end
    check("to_req_cycles", 64'(cnt), 64'(TO));
    check("to_rsp_valid", 64'(c2_rsp_valid), 64'd1);
    check("to_rsp_data", c2_rsp_data, ONES);
    idle(3);
    rd_local(16'h000E, 2'd1, 9'h021, 1'b0);
    wait_rsp("status_to1", 9'h021, 64'h0000_0000_0000_0001);
    idle(2);

    // Backlog: stall on a user read, push 5 local reads into a 4-entry queue
    rd_user(16'h0042, 2'd1, 9'h030, 64'h77, 1'b1);
    wait_req("stall_req_seen");
    rd_local(16'h0000, 2'd1, 9'h031, 1'b0);
    rd_local(16'h0001, 2'd0, 9'h032, 1'b0);
    rd_local(16'h000A, 2'd1, 9'h033, 1'b0);
    rd_local(16'h0004, 2'd1, 9'h034, 1'b0);
    rd_local(16'h0008, 2'd1, 9'h035, 1'b1);
    ack(64'h77);
    idle(20);
    rd_local(16'h000E, 2'd1, 9'h036, 1'b0);
    wait_rsp("status_err", 9'h036, 64'h8000_0000_0000_0001);
    idle(2);
    rd_local(16'h000C, 2'd1, 9'h037, 1'b0);
    wait_rsp("rd_count_14", 9'h037, 64'd14);
    idle(3);

    // Reset during USR_WAIT aborts the read and clears SCRATCH
    wr(16'h000A, 2'd1, 64'hCAFE_F00D_CAFE_F00D);
    rd_user(16'h0043, 2'd1, 9'h040, '0, 1'b0);
    wait_req("abort_req_seen");
    SoftReset_n = 1'b0;
    #1;
    check("abort_req_low",   64'(usr_rd_req),   64'd0);
    check("abort_raddr_low", 64'(usr_rd_addr),  64'd0);
    check("abort_rsp_low",   64'(c2_rsp_valid), 64'd0);
    m_scratch = '0; m_rd_count = '0; m_to_count = '0; m_err = 1'b0;
    idle(3);
    SoftReset_n = 1'b1;
    idle(10);
    rd_local(16'h000A, 2'd1, 9'h041, 1'b0);
    wait_rsp("scratch_after_rst", 9'h041, 64'd0);
    idle(2);
    rd_local(16'h000E, 2'd1, 9'h042, 1'b0);
    wait_rsp("status_after_rst", 9'h042, 64'd0);
    idle(2);

    // Simultaneous read and write: write lands, read dropped, ERR set
    m_err = 1'b1;
    m_write(16'h000A, 2'd1, 64'h5555_AAAA_5555_AAAA);
    drive(1'b1, 1'b1, 16'h000A, 2'd1, 9'h050, 64'h5555_AAAA_5555_AAAA);
    idle(3);
    rd_local(16'h000A, 2'd1, 9'h051, 1'b0);
    wait_rsp("collide_wr", 9'h051, 64'h5555_AAAA_5555_AAAA);
    idle(2);
    rd_local(16'h000E, 2'd1, 9'h052, 1'b0);
    wait_rsp("collide_err", 9'h052, 64'h8000_0000_0000_0000);

    idle(10);
    check("rsp_drained", 64'(exp_rsp.size()), 64'd0);
    check("uwr_drained", 64'(exp_uwr.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
